// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the width of the bubble-cycle counter.
package pipe_ctrl_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    IMM  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr_n clears it asynchronously.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the IF/ID/EX pipeline: load-use bubbles, two-byte
// instruction assembly, branch flushes and HLT, plus a count of bubble cycles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_is_2byte,
  input  logic        id_halt,
  input  logic [1:0]  id_rs_a,
  input  logic [1:0]  id_rs_b,
  input  logic        id_uses_a,
  input  logic        id_uses_b,
  input  logic        ex_memtoreg,
  input  logic        ex_regwrite,
  input  logic [1:0]  ex_dist,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        imm_capture,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  state_e state;
  state_e state_next;
  logic   load_use;

  // Handshake-free control block: every output is a same-cycle function of
  // state and inputs; the pipeline registers act on them at the next clk edge.
  assign load_use = id_valid && ex_memtoreg && ex_regwrite &&
                    ((id_uses_a && (ex_dist == id_rs_a)) ||
                     (id_uses_b && (ex_dist == id_rs_b)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    imm_capture = 1'b0;
    halted      = 1'b0;
    state_next  = state;

    unique case (state)
      RUN: begin
        if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_next  = RUN;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_next  = RUN;
        end else if (id_valid && id_halt) begin
          // HLT itself moves on into EX; fetch freezes behind it.
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          state_next  = HALT;
        end else if (id_valid && id_is_2byte) begin
          // Keep the opcode in IF/ID while the immediate byte is fetched.
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_next  = IMM;
        end
      end
      IMM: begin
        // EX holds the bubble inserted on entry, so load_use cannot apply here.
        if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          imm_capture = 1'b1;
        end
        state_next = RUN;
      end
      HALT: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        halted      = 1'b1;
        state_next  = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase

    if (!rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      imm_capture = 1'b0;
      halted      = 1'b0;
      state_next  = RUN;
    end
  end

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (id_ex_flush && (state != HALT)),
    .count (stall_cnt)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst as elsewhere in the pipeline.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 id_valid  input  1  the IF/ID register holds a real instruction.
REQ-005 id_is_2byte  input  1  the ID opcode needs a second (immediate) byte.
REQ-006 id_halt  input  1  the ID opcode is HLT.
REQ-007 id_rs_a, id_rs_b  input  2 each  ID source register indices.
REQ-008 id_uses_a, id_uses_b  input  1 each  the ID instruction reads rs_a / rs_b.
REQ-009 ex_memtoreg, ex_regwrite  input  1 each  control bits held in the ID/EX register.
REQ-010 ex_dist  input  2  destination register held in the ID/EX register.
REQ-011 branch_taken  input  1  the EX stage resolves a taken branch or jump.
REQ-012 pc_en  output  1  PC update enable.
REQ-013 if_id_en  output  1  IF/ID load enable.
REQ-014 if_id_flush  output  1  IF/ID synchronous clear.
REQ-015 id_ex_flush  output  1  inserts a bubble into ID/EX (all control bits cleared).
REQ-016 imm_capture  output  1  ID/EX immediate field loads the fetched byte.
REQ-017 halted  output  1  the core is in HALT.
REQ-018 stall_cnt  output  16  saturating count of bubble cycles.

Function
REQ-019 The state machine SHALL have three states: RUN, IMM, and HALT; the state register is the only control state.
REQ-020 load_use SHALL be the AND of id_valid, ex_memtoreg, and ex_regwrite, ANDed with ((id_uses_a & ex_dist==id_rs_a) | (id_uses_b & ex_dist==id_rs_b)).
REQ-021 RUN default SHALL be: pc_en=1, if_id_en=1, with all flushes and imm_capture at 0; next state RUN.
REQ-022 RUN priority SHALL be: branch_taken > load_use > id_halt > id_is_2byte; only the highest-priority active condition acts.
REQ-023 RUN and branch_taken: if_id_flush=1 and id_ex_flush=1; next state RUN.
REQ-024 RUN and load_use: pc_en=0, if_id_en=0, id_ex_flush=1; next state RUN, with the hazard re-evaluated the following cycle (exactly one bubble per load-use).
REQ-025 RUN, id_valid and id_halt: pc_en=0, if_id_en=0, id_ex_flush=0 (HLT itself proceeds); next state HALT.
REQ-026 RUN, id_valid and id_is_2byte: pc_en=1, if_id_en=0, id_ex_flush=1; next state IMM.
REQ-027 IMM SHALL drive pc_en=1, if_id_en=1, and imm_capture=1, so the opcode and immediate enter ID/EX together; next state RUN.
REQ-028 In IMM, branch_taken SHALL win: if_id_flush=1, id_ex_flush=1, imm_capture=0; next state RUN.
REQ-029 In IMM, load_use SHALL be ignored, because EX holds a bubble.
REQ-030 HALT SHALL drive pc_en=0, if_id_en=0, id_ex_flush=1, and halted=1; it is left only by reset.
REQ-031 In HALT, branch_taken SHALL be ignored.
REQ-032 Outputs SHALL be combinational from state and inputs, with zero-cycle latency; state changes take effect on the next clk edge.
REQ-033 stall_cnt SHALL increment by 1 on every clk edge where id_ex_flush=1 and the state is not HALT, saturating at 16'hFFFF with no wrap.

Reset
REQ-034 While rst=0, the block SHALL force: state=RUN, stall_cnt=0, pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, imm_capture=0, halted=0.
REQ-035 Assertion of rst in any state, including mid-IMM or HALT, SHALL immediately abort that state; the partial 2-byte instruction is discarded.
REQ-036 On the first clk edge after rst rises, the block SHALL operate per RUN rules.

Structure
REQ-037 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, IMM, HALT) and the STALL_CNT_W=16 constant.
REQ-038 The block SHALL contain one sub-module, sat_counter (parameterised width, inc enable, async active-low clear), used for stall_cnt.

Verification
REQ-039 Load-use scenario: ex_memtoreg=1, ex_regwrite=1, ex_dist=2, id_rs_a=2, id_uses_a=1 -> exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt goes 0->1.
REQ-040 2-byte scenario: id_is_2byte=1 in RUN -> cycle 1 gives pc_en=1, if_id_en=0, id_ex_flush=1; cycle 2 gives imm_capture=1, if_id_en=1; then back to RUN.
REQ-041 Branch-in-IMM scenario: branch_taken=1 during IMM -> if_id_flush=1, id_ex_flush=1, imm_capture=0; next state RUN.
REQ-042 Simultaneous-event scenario: branch_taken=1 together with load_use=1 and id_is_2byte=1 -> branch response only; next state RUN.
REQ-043 Halt and reset scenario: id_halt=1 -> halted=1, pc_en=0 held for 10 cycles with branch_taken pulses ignored; rst=0 mid-HALT -> halted=0 and stall_cnt=0 asynchronously.
REQ-044 Saturation scenario: 70000 consecutive load-use stalls -> stall_cnt=16'hFFFF, with no wrap.
